channel_arbiter: RTL and testbench
==================================

CHANNEL_ARBITER -- requirements
Module: channel_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum GRANT cycles per grant before forced release (legal range 2..255).
REQ-002 Parameter GUARD_CYCLES, default 2, idle cycles inserted between two grants (legal range 1..15).
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req  input  8  request vector; bit i high = requester i wants the shared channel.
REQ-006 Port done  input  1  one-cycle release strobe from the current owner.
REQ-007 Port grant  output  8  one-hot grant vector; all-zero when channel is unowned.
REQ-008 Port grant_id  output  3  binary index of current owner; 0 when grant_valid=0.
REQ-009 Port grant_valid  output  1  high while any grant bit is high.
REQ-010 Port timeout  output  1  one-cycle pulse when a grant is forcibly released by MAX_HOLD.
REQ-011 All outputs SHALL be driven directly from registers.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, GRANT, GUARD.
REQ-013 IDLE: if req==0, remain IDLE; else select winner and enter GRANT on the same edge.
REQ-014 Winner SHALL be the first set bit of req searched upward from rr_ptr, wrapping 7->0 (round robin).
REQ-015 rr_ptr (3 bits) SHALL load (winner+1) mod 8 on each grant; 7 wraps to 0.
REQ-016 Latency: req sampled at edge k in IDLE -> grant, grant_id, grant_valid valid immediately after edge k.
REQ-017 On entry to GRANT, hold counter SHALL clear to 0; it increments every GRANT cycle.
REQ-018 GRANT -> GUARD when done=1, or when req[grant_id]=0 (owner withdrew), or when hold counter = MAX_HOLD-1.
REQ-019 Release by MAX_HOLD only SHALL assert timeout for exactly the cycle following the release edge.
REQ-020 done=1 coincident with hold counter = MAX_HOLD-1 SHALL count as normal release; no timeout pulse.
REQ-021 grant, grant_id, grant_valid SHALL clear on the edge that enters GUARD.
REQ-022 GUARD SHALL last exactly GUARD_CYCLES cycles, then return to IDLE; req ignored during GUARD.
REQ-023 Requests from non-owners during GRANT SHALL be ignored (no queueing); they compete again in IDLE.
REQ-024 done asserted in IDLE or GUARD SHALL have no effect.
REQ-025 Maximum grant length = MAX_HOLD cycles; minimum grant length = 1 cycle.
REQ-026 grant SHALL never have more than one bit set; grant_valid SHALL equal |grant at all times.

Reset
REQ-027 rst=1 SHALL immediately (asynchronously) force state=IDLE, rr_ptr=0, hold and guard counters=0.
REQ-028 rst=1 SHALL immediately force grant=0, grant_id=0, grant_valid=0, timeout=0, including mid-grant.
REQ-029 After rst deassertion, first arbitration SHALL occur on the first rising edge with req!=0.
REQ-030 No timeout pulse SHALL be produced for a grant aborted by reset.

Verification
REQ-031 Reset, req=8'b1000_0001 held -> first grant to 0 (grant=8'h01); after done and 2 guard cycles grant to 7 (8'h80).
REQ-032 rr_ptr=6, req=8'b0010_0001 -> winner 0 (wrap past 7), grant_id=0, rr_ptr becomes 1.
REQ-033 MAX_HOLD=16, owner 3 holds req, no done -> grant high exactly 16 cycles, timeout pulses 1 cycle, then 2 idle cycles.
REQ-034 done asserted on 16th GRANT cycle -> release, timeout stays 0.
REQ-035 Owner 5 drops req[5] mid-grant -> grant clears next edge, GUARD entered, no timeout.
REQ-036 rst pulsed asynchronously mid-GRANT (between edges) -> grant=0 and grant_valid=0 without waiting for clk; next arbitration starts from rr_ptr=0.

Source files
------------

// File: rtl/channel_arbiter.sv
// Round-robin arbiter for one shared channel among eight requesters.
// A grant ends on done, owner withdrawal or MAX_HOLD expiry, then a guard gap follows.
module channel_arbiter #(
  parameter int MAX_HOLD     = 16,
  parameter int GUARD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD - 1);
  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

  state_t     state, state_next;
  logic [2:0] rr_ptr, rr_ptr_next;
  logic [7:0] hold_cnt, hold_next;
  logic [3:0] guard_cnt, guard_next;
  logic [7:0] grant_next;
  logic [2:0] grant_id_next;
  logic       grant_valid_next;
  logic       timeout_next;

  logic [2:0] winner;
  logic [2:0] scan_idx;
  logic       found;
  logic       owner_req;
  logic       release_now;

  // Scan upward from rr_ptr; the 3-bit index wraps 7 -> 0 naturally.
  always_comb begin
    winner   = rr_ptr;
    scan_idx = rr_ptr;
    found    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = rr_ptr + i[2:0];
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign owner_req   = req[grant_id];
  assign release_now = done || !owner_req || (hold_cnt == HOLD_LAST);

  always_comb begin
    state_next       = state;
    rr_ptr_next      = rr_ptr;
    hold_next        = hold_cnt;
    guard_next       = guard_cnt;
    grant_next       = grant;
    grant_id_next    = grant_id;
    grant_valid_next = grant_valid;
    timeout_next     = 1'b0;

    case (state)
      IDLE: begin
        if (|req) begin
          state_next       = GRANT;
          grant_next       = 8'd1 << winner;
          grant_id_next    = winner;
          grant_valid_next = 1'b1;
          rr_ptr_next      = winner + 3'd1;
          hold_next        = 8'd0;
        end
      end

      GRANT: begin
        if (release_now) begin
          state_next       = GUARD;
          grant_next       = 8'd0;
          grant_id_next    = 3'd0;
          grant_valid_next = 1'b0;
          hold_next        = 8'd0;
          guard_next       = 4'd0;
          // Only an expiry with the owner still requesting and not signalling done is a timeout.
          timeout_next     = !done && owner_req;
        end else begin
          hold_next = hold_cnt + 8'd1;
        end
      end

      GUARD: begin
        if (guard_cnt == GUARD_LAST) begin
          state_next = IDLE;
          guard_next = 4'd0;
        end else begin
          guard_next = guard_cnt + 4'd1;
        end
      end

      default: begin
        state_next       = IDLE;
        grant_next       = 8'd0;
        grant_id_next    = 3'd0;
        grant_valid_next = 1'b0;
        hold_next        = 8'd0;
        guard_next       = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 3'd0;
      hold_cnt    <= 8'd0;
      guard_cnt   <= 4'd0;
      grant       <= 8'd0;
      grant_id    <= 3'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      rr_ptr      <= rr_ptr_next;
      hold_cnt    <= hold_next;
      guard_cnt   <= guard_next;
      grant       <= grant_next;
      grant_id    <= grant_id_next;
      grant_valid <= grant_valid_next;
      timeout     <= timeout_next;
    end
  end

endmodule

// File: tb/tb_channel_arbiter.sv
// Directed bench for channel_arbiter: vector table plus hand-written hold/timeout/reset sequences.
module tb_channel_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int checks_total;
  int checks_passed;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] exp_grant;
    logic [2:0] exp_id;
    logic       exp_valid;
    logic       exp_timeout;
    string      name;
  } vec_t;

  vec_t vecs[21];

  channel_arbiter #(
    .MAX_HOLD    (16),
    .GUARD_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eg, input logic [2:0] eid,
                             input logic ev, input logic et);
    checks_total++;
    if (grant === eg && grant_id === eid && grant_valid === ev && timeout === et) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got grant=%h id=%0d valid=%b timeout=%b, want grant=%h id=%0d valid=%b timeout=%b",
               name, grant, grant_id, grant_valid, timeout, eg, eid, ev, et);
    end
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;

    // Inputs applied before an edge, outputs expected just after it. rr_ptr starts at 0.
    vecs[0]  = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "first grant to 0"};
    vecs[1]  = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "done releases 0"};
    vecs[2]  = '{8'h81, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "guard cycle 2"};
    vecs[3]  = '{8'h81, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "back to idle"};
    vecs[4]  = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, "round robin to 7"};
    vecs[5]  = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "done releases 7"};
    vecs[6]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "guard no req"};
    vecs[7]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "to idle no req"};
    vecs[8]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "idle stays idle"};
    vecs[9]  = '{8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0, "grant 5, done in idle ignored"};
    vecs[10] = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "owner 5 holds"};
    vecs[11] = '{8'h21, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "non-owner ignored"};
    vecs[12] = '{8'h01, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "owner 5 withdraws"};
    vecs[13] = '{8'h21, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "guard ignores req and done"};
    vecs[14] = '{8'h21, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "idle after withdraw"};
    vecs[15] = '{8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "rr 6 wraps to 0"};
    vecs[16] = '{8'h21, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "done releases 0 again"};
    vecs[17] = '{8'h21, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "guard after wrap"};
    vecs[18] = '{8'h21, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "idle after wrap"};
    vecs[19] = '{8'h21, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "rr is 1 so 5 wins"};
    vecs[20] = '{8'h21, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "done releases 5"};

    rst = 1'b1;
    applyStimulus(8'h00, 1'b0);
    #12;
    checkOutput("reset state", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stepClock();
    checkOutput("idle after reset no req", 8'h00, 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].req, vecs[i].done);
      stepClock();
      checkOutput(vecs[i].name, vecs[i].exp_grant, vecs[i].exp_id, vecs[i].exp_valid,
                  vecs[i].exp_timeout);
    end

    // MAX_HOLD expiry: owner 3 holds for 16 cycles, then a one-cycle timeout pulse.
    applyStimulus(8'h08, 1'b0);
    stepClock();
    checkOutput("guard before 3", 8'h00, 3'd0, 1'b0, 1'b0);
    stepClock();
    checkOutput("idle before 3", 8'h00, 3'd0, 1'b0, 1'b0);
    stepClock();
    checkOutput("grant 3 cycle 1", 8'h08, 3'd3, 1'b1, 1'b0);
    for (int c = 2; c <= 16; c++) begin
      stepClock();
      checkOutput($sformatf("hold 3 cycle %0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
    end
    stepClock();
    checkOutput("timeout pulse", 8'h00, 3'd0, 1'b0, 1'b1);
    stepClock();
    checkOutput("timeout one cycle", 8'h00, 3'd0, 1'b0, 1'b0);
    stepClock();
    checkOutput("idle after timeout", 8'h00, 3'd0, 1'b0, 1'b0);

    // done on the 16th grant cycle is a normal release.
    stepClock();
    checkOutput("regrant 3 cycle 1", 8'h08, 3'd3, 1'b1, 1'b0);
    for (int c = 2; c <= 16; c++) begin
      stepClock();
      checkOutput($sformatf("rehold 3 cycle %0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
    end
    applyStimulus(8'h08, 1'b1);
    stepClock();
    checkOutput("done at max hold no timeout", 8'h00, 3'd0, 1'b0, 1'b0);
    applyStimulus(8'h08, 1'b0);
    stepClock();
    checkOutput("still no timeout", 8'h00, 3'd0, 1'b0, 1'b0);
    stepClock();
    checkOutput("idle before reset test", 8'h00, 3'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant cycle, then arbitration restarts at 0.
    stepClock();
    checkOutput("grant 3 before reset", 8'h08, 3'd3, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async reset clears grant", 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    applyStimulus(8'h21, 1'b0);
    stepClock();
    checkOutput("rr reset to 0", 8'h01, 3'd0, 1'b1, 1'b0);
    applyStimulus(8'h21, 1'b1);
    stepClock();
    checkOutput("release after reset", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
